// File: rtl/rs_issue_selector.sv
`default_nettype none
// ============================================================================
// Module   : rs_issue_selector
// Brief    : Picks up to ISSUE_WIDTH ready reservation-station entries per
//            cycle and presents them as registered per-port grants. A port
//            that is valid but whose FU is not ready holds its grant (stall).
//            Free ports are filled in ascending port order from a
//            round-robin start pointer.
//            Optional macro RS_ISSUE_RR_EN enables the rotating start
//            pointer; without it the start is fixed at entry 0 (lowest
//            index first).
// Revision : 1.0 - initial release
// ============================================================================
module rs_issue_selector #(
    parameter int RS_DEPTH    = 64,
    parameter int ISSUE_WIDTH = 2,
    localparam int c_IDX_W    = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic [RS_DEPTH-1:0]                    ready_vec,
    input  logic [ISSUE_WIDTH-1:0]                 fu_ready,
    output logic [ISSUE_WIDTH-1:0]                 issue_valid,
    output logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]   issue_grant_vec,
    output logic [ISSUE_WIDTH-1:0][c_IDX_W-1:0]    issue_idx,
    output logic [RS_DEPTH-1:0]                    issue_fire_vec
);

    localparam logic [c_IDX_W:0]   c_DEPTH_EXT = (c_IDX_W+1)'(RS_DEPTH);
    localparam logic [c_IDX_W-1:0] c_ONE       = c_IDX_W'(1);

    logic [ISSUE_WIDTH-1:0]                 r_valid;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]   r_grant;
    logic [ISSUE_WIDTH-1:0][c_IDX_W-1:0]    r_idx;

    logic [c_IDX_W-1:0]                     w_rr_ptr;
    logic [ISSUE_WIDTH-1:0]                 w_port_free;
    logic [RS_DEPTH-1:0]                    w_mask;
    logic [RS_DEPTH-1:0]                    w_cand;
    logic [RS_DEPTH-1:0]                    w_rot_cand;
    logic [RS_DEPTH-1:0]                    w_fire_vec;
    logic [ISSUE_WIDTH-1:0]                 w_pick_found;
    logic [ISSUE_WIDTH-1:0][c_IDX_W-1:0]    w_pick_off;
    logic [ISSUE_WIDTH-1:0][c_IDX_W-1:0]    w_pick_idx;
    logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]   w_pick_onehot;

    // Modular add of an entry index and an offset, wrapping at RS_DEPTH.
    function automatic logic [c_IDX_W-1:0] wrap_add(input logic [c_IDX_W-1:0] a,
                                                    input logic [c_IDX_W-1:0] b);
        logic [c_IDX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= c_DEPTH_EXT) begin
            sum = sum - c_DEPTH_EXT;
        end
        return sum[c_IDX_W-1:0];
    endfunction

    // Occupied entries (including those firing now) are masked out so an
    // entry leaving this cycle is never re-granted before the RS frees it.
    always_comb begin
        w_mask     = '0;
        w_fire_vec = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            w_port_free[i] = !r_valid[i] || fu_ready[i];
            if (r_valid[i]) begin
                w_mask = w_mask | r_grant[i];
            end
            if (r_valid[i] && fu_ready[i]) begin
                w_fire_vec = w_fire_vec | r_grant[i];
            end
        end
        w_cand     = ready_vec & ~w_mask;
        // Rotate so that bit 0 is the entry at rr_ptr: search order becomes
        // plain ascending bit order.
        w_rot_cand = RS_DEPTH'({w_cand, w_cand} >> w_rr_ptr);
    end

    // Free ports, lowest port first, each take the next remaining candidate.
    always_comb begin
        logic [RS_DEPTH-1:0] remaining;
        remaining     = w_rot_cand;
        w_pick_found  = '0;
        w_pick_off    = '0;
        w_pick_idx    = '0;
        w_pick_onehot = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (w_port_free[i]) begin
                for (int k = 0; k < RS_DEPTH; k++) begin
                    if (!w_pick_found[i] && remaining[k]) begin
                        w_pick_found[i] = 1'b1;
                        w_pick_off[i]   = c_IDX_W'(k);
                        remaining[k]    = 1'b0;
                    end
                end
            end
            if (w_pick_found[i]) begin
                w_pick_idx[i]    = wrap_add(w_rr_ptr, w_pick_off[i]);
                w_pick_onehot[i] = RS_DEPTH'(1) << w_pick_idx[i];
            end
        end
    end

`ifdef RS_ISSUE_RR_EN
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] w_rr_ptr_next;

    // The highest-numbered port granted holds the furthest entry in search
    // order, so the next search starts just past it.
    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (w_pick_found[i]) begin
                w_rr_ptr_next = wrap_add(w_pick_idx[i], c_ONE);
            end
        end
    end

    // Round-robin start pointer; reset and flush return it to entry 0.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`else
    assign w_rr_ptr = '0;
`endif

    // Grant registers: stalled ports hold, free ports load the new pick (or
    // go idle when nothing is left).
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_valid <= '0;
            r_grant <= '0;
            r_idx   <= '0;
        end else begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (w_port_free[i]) begin
                    r_valid[i] <= w_pick_found[i];
                    r_grant[i] <= w_pick_onehot[i];
                    r_idx[i]   <= w_pick_idx[i];
                end
            end
        end
    end

    assign issue_valid     = r_valid;
    assign issue_grant_vec = r_grant;
    assign issue_idx       = r_idx;
    assign issue_fire_vec  = w_fire_vec;

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_issue_selector
// Brief    : Self-checking bench for rs_issue_selector with directed scenarios
//            and randomized traffic compared against a queue-based model.
//            Honors RS_ISSUE_RR_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_issue_selector;

    localparam int D  = 64;
    localparam int W  = 2;
    localparam int IW = 6;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    flush;
    logic [D-1:0]            ready_vec;
    logic [W-1:0]            fu_ready;
    logic [W-1:0]            issue_valid;
    logic [W-1:0][D-1:0]     issue_grant_vec;
    logic [W-1:0][IW-1:0]    issue_idx;
    logic [D-1:0]            issue_fire_vec;

    int checks = 0;
    int errors = 0;

    // Reference state: per-port grant and the search start pointer.
    bit m_valid [W];
    int m_idx   [W];
    int m_ptr;

    rs_issue_selector #(
        .RS_DEPTH    (D),
        .ISSUE_WIDTH (W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .ready_vec       (ready_vec),
        .fu_ready        (fu_ready),
        .issue_valid     (issue_valid),
        .issue_grant_vec (issue_grant_vec),
        .issue_idx       (issue_idx),
        .issue_fire_vec  (issue_fire_vec)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D-1:0] exp_fire();
        logic [D-1:0] f;
        f = '0;
        for (int i = 0; i < W; i++) begin
            if (m_valid[i] && fu_ready[i]) f[m_idx[i]] = 1'b1;
        end
        return f;
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_step();
        bit taken [D];
        int q [$];
        bit nv [W];
        int ni [W];
        int last;
        if (reset || flush) begin
            for (int i = 0; i < W; i++) begin
                m_valid[i] = 1'b0;
                m_idx[i]   = 0;
            end
            m_ptr = 0;
            return;
        end
        for (int e = 0; e < D; e++) taken[e] = 1'b0;
        for (int i = 0; i < W; i++) if (m_valid[i]) taken[m_idx[i]] = 1'b1;
        for (int s = 0; s < D; s++) begin
            int e;
            e = (m_ptr + s) % D;
            if (ready_vec[e] && !taken[e]) q.push_back(e);
        end
        last = -1;
        for (int i = 0; i < W; i++) begin
            if (m_valid[i] && !fu_ready[i]) begin
                nv[i] = 1'b1;
                ni[i] = m_idx[i];
            end else if (q.size() > 0) begin
                nv[i] = 1'b1;
                ni[i] = q.pop_front();
                last  = ni[i];
            end else begin
                nv[i] = 1'b0;
                ni[i] = 0;
            end
        end
        for (int i = 0; i < W; i++) begin
            m_valid[i] = nv[i];
            m_idx[i]   = ni[i];
        end
        if (last >= 0) m_ptr = (last + 1) % D;
`ifndef RS_ISSUE_RR_EN
        m_ptr = 0;
`endif
    endtask

    task automatic check_outputs(input string tag);
        logic [W-1:0]         ev;
        logic [W-1:0][D-1:0]  eg;
        logic [W-1:0][IW-1:0] ei;
        ev = '0;
        eg = '0;
        ei = '0;
        for (int i = 0; i < W; i++) begin
            if (m_valid[i]) begin
                ev[i]           = 1'b1;
                eg[i][m_idx[i]] = 1'b1;
                ei[i]           = IW'(m_idx[i]);
            end
        end
        check({tag, ".valid"}, 256'(issue_valid), 256'(ev));
        check({tag, ".grant"}, 256'(issue_grant_vec), 256'(eg));
        check({tag, ".idx"}, 256'(issue_idx), 256'(ei));
        if (issue_valid == 2'b11) begin
            check({tag, ".nodup"}, 256'(issue_idx[0] == issue_idx[1]), 256'(0));
        end
    endtask

    // One clock: check the combinational fire vector mid-cycle, then the
    // registered outputs just after the edge.
    task automatic cycle(input string tag);
        @(negedge clock);
        check({tag, ".fire"}, 256'(issue_fire_vec), 256'(exp_fire()));
        model_step();
        @(posedge clock);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        cycle("rst");
        reset = 1'b0;
    endtask

    initial begin
        logic [D-1:0] r0;
        reset     = 1'b1;
        flush     = 1'b0;
        ready_vec = '0;
        fu_ready  = '0;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < W; i++) begin
            m_valid[i] = 1'b0;
            m_idx[i]   = 0;
        end
        m_ptr = 0;
        check_outputs("reset");
        check("reset.fire", 256'(issue_fire_vec), 256'(0));
        reset = 1'b0;

        // Two ready entries, both ports free.
        ready_vec = 64'h6;
        fu_ready  = 2'b11;
        cycle("basic");
        check("basic.v", 256'(issue_valid), 256'(2'b11));
        check("basic.i0", 256'(issue_idx[0]), 256'(1));
        check("basic.i1", 256'(issue_idx[1]), 256'(2));
        // Start-pointer effect: candidates {0,4} with entries 1,2 leaving.
        ready_vec = 64'h11;
        cycle("ptr3");
`ifdef RS_ISSUE_RR_EN
        check("ptr3.i0", 256'(issue_idx[0]), 256'(4));
        check("ptr3.i1", 256'(issue_idx[1]), 256'(0));
`else
        check("ptr3.i0", 256'(issue_idx[0]), 256'(0));
        check("ptr3.i1", 256'(issue_idx[1]), 256'(4));
`endif

        // Port 0 stalls on entry 5; entry 5 must never move to port 1.
        do_reset();
        ready_vec = 64'h20;
        fu_ready  = 2'b11;
        cycle("hold0");
        fu_ready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            cycle("hold");
            check("hold.v0", 256'(issue_valid[0]), 256'(1));
            check("hold.i0", 256'(issue_idx[0]), 256'(5));
            check("hold.p1", 256'(issue_valid[1] && issue_idx[1] == 5), 256'(0));
        end

        // Wrap of the search across RS_DEPTH-1 -> 0.
        do_reset();
        ready_vec = 64'h1 << 61;
        fu_ready  = 2'b11;
        cycle("wrapA");
        ready_vec = (64'h1 << 63) | 64'h3;
        cycle("wrapB");
`ifdef RS_ISSUE_RR_EN
        check("wrap.i0", 256'(issue_idx[0]), 256'(63));
        check("wrap.i1", 256'(issue_idx[1]), 256'(0));
`else
        check("wrap.i0", 256'(issue_idx[0]), 256'(0));
        check("wrap.i1", 256'(issue_idx[1]), 256'(1));
`endif
        cycle("wrapC");

        // Flush with port 0 firing: fire still visible, then all cleared.
        do_reset();
        ready_vec = 64'h3;
        fu_ready  = 2'b11;
        cycle("flA");
        flush    = 1'b1;
        fu_ready = 2'b01;
        cycle("flush");
        check("flush.v", 256'(issue_valid), 256'(0));
        flush     = 1'b0;
        ready_vec = (64'h1 << 63) | 64'h2;
        fu_ready  = 2'b11;
        cycle("flC");
        check("flush.i0", 256'(issue_idx[0]), 256'(1));
        check("flush.i1", 256'(issue_idx[1]), 256'(63));

        // Saturated issue: everything ready, both FUs always accepting.
        do_reset();
        ready_vec = '1;
        fu_ready  = 2'b11;
        for (int c = 0; c < 40; c++) begin
            cycle("sat");
`ifdef RS_ISSUE_RR_EN
            check("sat.i0", 256'(issue_idx[0]), 256'((2 * c) % D));
            check("sat.i1", 256'(issue_idx[1]), 256'((2 * c + 1) % D));
`endif
        end

        // Reset during a stall: grants dropped without firing.
        do_reset();
        ready_vec = 64'h3;
        fu_ready  = 2'b11;
        cycle("rsA");
        fu_ready = 2'b00;
        reset    = 1'b1;
        cycle("rsB");
        reset     = 1'b0;
        ready_vec = '0;
        fu_ready  = 2'b11;
        cycle("rsC");
        check("rs.v", 256'(issue_valid), 256'(0));
        check("rs.fire", 256'(issue_fire_vec), 256'(0));

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(63) == 0);
            flush = ($urandom_range(15) == 0);
            r0    = {$urandom(), $urandom()};
            case ($urandom_range(3))
                0: ready_vec = r0;
                1: ready_vec = r0 & {$urandom(), $urandom()} & {$urandom(), $urandom()};
                2: ready_vec = (64'h1 << $urandom_range(63)) | (64'h1 << $urandom_range(63));
                default: ready_vec = r0 & 64'hC000_0000_0000_0003;
            endcase
            fu_ready = 2'($urandom_range(3));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
